// File: rtl/counter_sequencer.sv
// counter_sequencer: accepts a run command (step count + inter-step gap) over
// a valid/ready handshake and drives the enable of a 2-bit mod-4 counter for
// exactly that many steps. It counts carry pulses, keeps a shadow copy of the
// counter state, flags any divergence and reports completion.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   cmd_valid/cmd_ready  command handshake (ready only while idle)
//   cmd_len, cmd_gap     step count, idle cycles between steps
//   pause, abort         freeze / terminate the current run
//   cnt_en               combinational enable to the counter's x input
//   cnt_a, cnt_b, cnt_z  counter state bits (A = MSB) and carry
//   busy, done           run in progress, one-cycle completion pulse
//   aborted, wraps       last run aborted, carry pulses in last run
//   final_state          shadow state captured at completion
//   err                  sticky shadow/counter mismatch
module counter_sequencer #(
  parameter int unsigned LEN_W = 8,
  parameter int unsigned GAP_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic [GAP_W-1:0] cmd_gap,
  input  logic             pause,
  input  logic             abort,
  output logic             cnt_en,
  input  logic             cnt_a,
  input  logic             cnt_b,
  input  logic             cnt_z,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [LEN_W-1:0] wraps,
  output logic [1:0]       final_state,
  output logic             err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_GAP  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [LEN_W-1:0]   rem_q, rem_d;
  logic [GAP_W-1:0]   gap_reload_q, gap_reload_d;
  logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic [1:0]         shadow_q, shadow_d;
  logic [LEN_W-1:0]   wraps_q, wraps_d;
  logic               aborted_q, aborted_d;
  logic [1:0]         final_q, final_d;
  logic               err_q, err_d;
  logic               step;

  // A step is taken on every edge where the enable is presented to the counter.
  assign step = (state_q == S_RUN) & ~pause & ~abort;

  // State register and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      rem_q        <= '0;
      gap_reload_q <= '0;
      gap_cnt_q    <= '0;
      shadow_q     <= '0;
      wraps_q      <= '0;
      aborted_q    <= 1'b0;
      final_q      <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      rem_q        <= rem_d;
      gap_reload_q <= gap_reload_d;
      gap_cnt_q    <= gap_cnt_d;
      shadow_q     <= shadow_d;
      wraps_q      <= wraps_d;
      aborted_q    <= aborted_d;
      final_q      <= final_d;
      err_q        <= err_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d      = state_q;
    rem_d        = rem_q;
    gap_reload_d = gap_reload_q;
    gap_cnt_d    = gap_cnt_q;
    shadow_d     = shadow_q;
    wraps_d      = wraps_q;
    aborted_d    = aborted_q;
    final_d      = final_q;
    err_d        = err_q;

    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          shadow_d     = {cnt_a, cnt_b};
          rem_d        = cmd_len;
          gap_reload_d = cmd_gap;
          wraps_d      = '0;
          aborted_d    = 1'b0;
          err_d        = 1'b0;
          state_d      = (cmd_len == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (abort) begin
          aborted_d = 1'b1;
          state_d   = S_DONE;
        end else if (step) begin
          shadow_d = shadow_q + 2'd1;
          rem_d    = rem_q - LEN_W'(1);
          // Carry only counts on an enabled edge; saturate rather than wrap.
          if (cnt_z && (wraps_q != '1)) begin
            wraps_d = wraps_q + LEN_W'(1);
          end
          if (rem_q == LEN_W'(1)) begin
            state_d = S_DONE;
          end else if (gap_reload_q != '0) begin
            gap_cnt_d = gap_reload_q;
            state_d   = S_GAP;
          end
        end
      end
      S_GAP: begin
        if (abort) begin
          aborted_d = 1'b1;
          state_d   = S_DONE;
        end else if (!pause) begin
          // Loaded with G on entry; leaving at 1 yields exactly G idle cycles.
          gap_cnt_d = gap_cnt_q - GAP_W'(1);
          if (gap_cnt_q == GAP_W'(1)) begin
            state_d = S_RUN;
          end
        end
      end
      S_DONE: begin
        final_d = shadow_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Pre-edge counter value must match the shadow while a run is active.
    if (((state_q == S_RUN) || (state_q == S_GAP)) && ({cnt_a, cnt_b} != shadow_q)) begin
      err_d = 1'b1;
    end
  end

  assign cnt_en      = step;
  assign cmd_ready   = (state_q == S_IDLE);
  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);
  assign aborted     = aborted_q;
  assign wraps       = wraps_q;
  assign final_state = final_q;
  assign err         = err_q;

endmodule

// File: tb/tb_counter_sequencer.sv
// Bench for counter_sequencer: a behavioural mod-4 counter model plus
// table-driven run vectors and hand-written error / reset sequences.
module tb_counter_sequencer;

  localparam int unsigned LEN_W = 8;
  localparam int unsigned GAP_W = 4;

  logic             clk;
  logic             rst_n;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [LEN_W-1:0] cmd_len;
  logic [GAP_W-1:0] cmd_gap;
  logic             pause;
  logic             abort;
  logic             cnt_en;
  logic             busy;
  logic             done;
  logic             aborted;
  logic [LEN_W-1:0] wraps;
  logic [1:0]       final_state;
  logic             err;

  // Counter model: 2-bit, enable-driven, carry z = A&B&x; flip toggles B.
  logic [1:0] ab;
  logic [1:0] cnt_init;
  logic       flip;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ab <= cnt_init;
    else        ab <= (ab + 2'(cnt_en)) ^ {1'b0, flip};
  end

  counter_sequencer #(.LEN_W(LEN_W), .GAP_W(GAP_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_len     (cmd_len),
    .cmd_gap     (cmd_gap),
    .pause       (pause),
    .abort       (abort),
    .cnt_en      (cnt_en),
    .cnt_a       (ab[1]),
    .cnt_b       (ab[0]),
    .cnt_z       (ab[1] & ab[0] & cnt_en),
    .busy        (busy),
    .done        (done),
    .aborted     (aborted),
    .wraps       (wraps),
    .final_state (final_state),
    .err         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  typedef struct {
    int len;
    int gap;
    int init;
    int pause_at;   // step count after which pause is raised (-1: never)
    int pause_len;
    int abort_at;   // step count after which abort is raised for a cycle (-1: never)
    int cycles;     // cycles from accept to the done cycle (exclusive)
    int pat;        // cnt_en pattern over those cycles, first cycle = MSB
    int wraps;
    int fin;
    int abrt;
  } vec_t;

  vec_t vecs[9];

  task automatic do_reset();
    cmd_valid = 1'b0; cmd_len = '0; cmd_gap = '0;
    pause = 1'b0; abort = 1'b0; flip = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Present a command for one cycle; returns at the negedge after the accept edge.
  task automatic send(input int len, input int gap);
    @(negedge clk);
    cmd_len   = LEN_W'(len);
    cmd_gap   = GAP_W'(gap);
    cmd_valid = 1'b1;
    #1;
    chk("cmd_ready at accept", int'(cmd_ready), 1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Wait (bounded) for the done cycle; returns #1 after its negedge.
  task automatic wait_done(input string nm);
    bit got = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      #1;
      if (done) begin got = 1'b1; break; end
    end
    chk({nm, " done seen"}, int'(got), 1);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int  steps = 0;
    int  cyc   = 0;
    int  pc    = 0;
    bit  ab_sent = 1'b0;
    bit  got   = 1'b0;
    logic [31:0] pat = '0;
    cnt_init = 2'(v.init);
    do_reset();
    send(v.len, v.gap);
    for (int k = 0; k < 100; k++) begin
      pause = (steps == v.pause_at) && (pc < v.pause_len);
      if (pause) pc++;
      abort = (steps == v.abort_at) && !ab_sent;
      if (abort) ab_sent = 1'b1;
      #1;
      if (done) begin got = 1'b1; break; end
      pat = {pat[30:0], cnt_en};
      if (cnt_en) steps++;
      cyc++;
      @(negedge clk);
    end
    pause = 1'b0;
    abort = 1'b0;
    chk($sformatf("v%0d done seen", idx), int'(got), 1);
    chk($sformatf("v%0d busy in done", idx), int'(busy), 1);
    chk($sformatf("v%0d cycles", idx), cyc, v.cycles);
    chk($sformatf("v%0d en pattern", idx), int'(pat), v.pat);
    @(negedge clk);
    #1;
    chk($sformatf("v%0d done pulse width", idx), int'(done), 0);
    chk($sformatf("v%0d busy after", idx), int'(busy), 0);
    chk($sformatf("v%0d wraps", idx), int'(wraps), v.wraps);
    chk($sformatf("v%0d final_state", idx), int'(final_state), v.fin);
    chk($sformatf("v%0d aborted", idx), int'(aborted), v.abrt);
    chk($sformatf("v%0d err", idx), int'(err), 0);
  endtask

  initial begin
    //        len gap init p_at p_len a_at cyc pattern wr fin abrt
    vecs[0] = '{6,  0,  0,  -1,  0,   -1,  6,  'h3F,   1, 2, 0};
    vecs[1] = '{3,  2,  0,  -1,  0,   -1,  7,  'h49,   0, 3, 0};
    vecs[2] = '{8,  0,  0,   2,  3,   -1,  11, 'h63F,  2, 0, 0};
    vecs[3] = '{10, 0,  0,  -1,  0,    4,  5,  'h1E,   1, 0, 1};
    vecs[4] = '{0,  0,  0,  -1,  0,   -1,  0,  'h0,    0, 0, 0};
    vecs[5] = '{0,  3,  3,  -1,  0,   -1,  0,  'h0,    0, 3, 0};
    vecs[6] = '{5,  1,  2,  -1,  0,   -1,  9,  'h155,  1, 3, 0};
    vecs[7] = '{2,  3,  0,   1,  2,   -1,  7,  'h41,   0, 2, 0};
    vecs[8] = '{10, 0,  0,   2,  5,    2,  3,  'h6,    0, 2, 1};

    cnt_init = 2'd0;
    do_reset();
    #1;
    chk("reset cmd_ready", int'(cmd_ready), 1);
    chk("reset cnt_en", int'(cnt_en), 0);
    chk("reset busy", int'(busy), 0);
    chk("reset done", int'(done), 0);
    chk("reset wraps", int'(wraps), 0);
    chk("reset final_state", int'(final_state), 0);
    chk("reset err", int'(err), 0);
    chk("reset aborted", int'(aborted), 0);

    for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

    // Counter knocked out of step mid-run: err sets, holds, clears on next accept.
    cnt_init = 2'd0;
    do_reset();
    send(6, 0);
    @(negedge clk);
    flip = 1'b1;
    @(negedge clk);
    flip = 1'b0;
    @(negedge clk);
    #1;
    chk("err set after divergence", int'(err), 1);
    wait_done("err run");
    @(negedge clk);
    #1;
    chk("err sticky after done", int'(err), 1);
    send(1, 0);
    wait_done("err clear run");
    @(negedge clk);
    #1;
    chk("err cleared by accept", int'(err), 0);

    // Reset mid-run returns every output to its reset value at once.
    cnt_init = 2'd0;
    do_reset();
    send(6, 0);
    wait_done("pre-reset run");
    @(negedge clk);
    #1;
    chk("pre-reset wraps", int'(wraps), 1);
    chk("pre-reset final_state", int'(final_state), 2);
    send(10, 0);
    @(negedge clk);
    cmd_valid = 1'b1;
    #1;
    chk("mid-run cmd_ready", int'(cmd_ready), 0);
    chk("mid-run busy", int'(busy), 1);
    chk("mid-run cnt_en", int'(cnt_en), 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("async rst cnt_en", int'(cnt_en), 0);
    chk("async rst busy", int'(busy), 0);
    chk("async rst cmd_ready", int'(cmd_ready), 1);
    chk("async rst done", int'(done), 0);
    chk("async rst wraps", int'(wraps), 0);
    chk("async rst final_state", int'(final_state), 0);
    chk("async rst aborted", int'(aborted), 0);
    chk("async rst err", int'(err), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/counter_sequencer.md
Name: counter_sequencer

Overview:
- Controller for the 2-bit enable-driven mod-4 counter (inputs: enable x; outputs: state bits A,B and carry z = A&B&x).
- Accepts a run command with step count and inter-step gap via a valid/ready handshake, then drives the counter's enable for exactly that many steps.
- Counts carry (wrap) pulses, tracks a shadow of the counter state, flags any state mismatch, and reports completion.
- Sits between the command source and one counter instance.

Parameters:
- LEN_W, 8, width of step count and wrap count.
- GAP_W, 4, width of the idle-cycle gap between enabled steps.

Ports:
- clk  input  1  rising-edge clock, shared with the counter.
- rst_n  input  1  asynchronous active-low reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  controller can accept a command (high only in IDLE).
- cmd_len  input  LEN_W  number of enabled steps.
- cmd_gap  input  GAP_W  idle cycles inserted after each step except the last.
- pause  input  1  freeze sequencing while high.
- abort  input  1  terminate the current run.
- cnt_en  output  1  drives the counter's x input.
- cnt_a, cnt_b  input  1 each  counter state bits A (MSB) and B.
- cnt_z  input  1  counter carry z.
- busy  output  1  high in RUN, GAP, DONE.
- done  output  1  one-cycle completion pulse.
- aborted  output  1  last run ended by abort.
- wraps  output  LEN_W  carry pulses counted in the last run.
- final_state  output  2  shadow counter state at completion.
- err  output  1  sticky mismatch between shadow and {cnt_a,cnt_b}.

Behaviour:
- Reset (async, rst_n=0): state IDLE; cnt_en=0, busy=0, done=0, aborted=0, wraps=0, final_state=0, err=0, cmd_ready=1; internal remaining, gap counter and shadow all 0.
- States: IDLE, RUN, GAP, DONE.
- Command accept at the rising edge where cmd_valid & cmd_ready:
  - shadow <= {cnt_a,cnt_b}; remaining <= cmd_len; gap_reload <= cmd_gap.
  - wraps <= 0, aborted <= 0, err <= 0.
  - Next state is RUN, or DONE if cmd_len = 0 (no enables are issued).
- cnt_en is combinational: (state==RUN) & ~pause & ~abort. No other state asserts it.
- Each edge with cnt_en=1 is one step:
  - shadow <= shadow+1 (mod 4); remaining <= remaining-1.
  - If cnt_z=1, wraps <= wraps+1, saturating at all-ones.
  - If remaining was 1, go to DONE.
  - Otherwise, if gap_reload>0, go to GAP with gap counter = gap_reload.
  - Otherwise stay in RUN, giving back-to-back enables.
- GAP: while pause=0, the gap counter decrements each cycle; when it reaches 1, go to RUN. A gap of G produces exactly G idle cycles.
- pause=1 in RUN or GAP: state, counters and shadow hold; cnt_en=0.
- abort=1 in RUN or GAP: next edge goes to DONE with aborted <= 1; cnt_en=0 in that cycle, so no step is taken. abort takes priority over pause. abort is ignored in IDLE and DONE.
- DONE: lasts exactly one cycle; done=1; final_state <= shadow; then IDLE. wraps, aborted and final_state hold until the next accept.
- Checking: in RUN and GAP, every cycle compare {cnt_a,cnt_b} with shadow; any mismatch sets err, which stays set until the next accept.
- cnt_z sampled outside an enabled edge is ignored.
- cmd_valid outside IDLE is ignored; it is not queued.

Test Plan:
- Counter at 0, cmd_len=6, gap=0 -> cnt_en high 6 consecutive cycles; wraps=1; final_state=2; done pulses the cycle after the 6th step; err=0.
- Counter at 0, cmd_len=3, gap=2 -> cnt_en pattern 1,0,0,1,0,0,1; final_state=3; wraps=0.
- cmd_len=8, gap=0, pause high 3 cycles after the 2nd step -> exactly 8 enables over 11 cycles; wraps=2; final_state=0.
- cmd_len=10, abort asserted in the cycle after the 4th step -> no further enables; done=1, aborted=1, final_state=0, wraps=1.
- cmd_len=0 -> no enables; done one cycle after accept; wraps=0; final_state equals the counter state at accept.
- Counter forced out of step (bench toggles B) mid-run -> err=1 and held; next accept clears it. rst_n pulsed low mid-run -> immediate IDLE, cnt_en=0, all outputs return to reset values.
